// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int WORD_BYTES    = 4;
  localparam int BYTE_OFS_BITS = 2;

  // The latency counter is loaded with LATENCY-1; 4 bits cover 1..15.
  function automatic logic [3:0] latency_init(input int latency);
    return 4'(latency - 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the core's driver (master) and the memory responder (slave).
interface data_mem_responder_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] wr_data;
  logic             d_ena;
  logic             wr_dena;
  logic [WIDTH-1:0] rd_data;
  logic             ack;
  logic             err;
  logic             busy;

  modport master (
    output address, wr_data, d_ena, wr_dena,
    input  rd_data, ack, err, busy
  );

  modport slave (
    input  address, wr_data, d_ena, wr_dena,
    output rd_data, ack, err, busy
  );

endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Word-wide RAM with synchronous write and combinational read.
module mem_word_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would force a flop-based
  // implementation instead of a RAM macro, and contents must survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one outstanding load/store, fixed LATENCY, one-cycle ack.
// Optional build macro MEM_ALIGN_CHECK_EN flags misaligned addresses as errors.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam logic [3:0] LAT_INIT = latency_init(LATENCY);

  mem_state_t          state_q;
  logic [3:0]          cnt_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [WIDTH-1:0]    wdata_q;
  logic                wr_q;
  logic                bad_q;
  logic [WIDTH-1:0]    hold_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic                ack_q;
  logic                err_q;
  logic                busy_q;

  logic [IDX_BITS-1:0] req_idx;
  logic                req_bad;
  logic [WIDTH-1:0]    ram_rdata;
  logic                ram_we;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    req_idx = bus.address[IDX_BITS+BYTE_OFS_BITS-1:BYTE_OFS_BITS];
    req_bad = |bus.address[WIDTH-1:IDX_BITS+BYTE_OFS_BITS];
`ifdef MEM_ALIGN_CHECK_EN
    req_bad = req_bad | (|bus.address[BYTE_OFS_BITS-1:0]);
`endif
  end

`ifndef MEM_ALIGN_CHECK_EN
  // Byte offset selects nothing when alignment is not enforced.
  logic unused_ofs;
  assign unused_ofs = ^bus.address[BYTE_OFS_BITS-1:0];
`endif

  // Writes commit on the edge that ends RESP; a reset on that edge cancels it.
  assign ram_we = (state_q == RESP) && wr_q && !bad_q && !reset;

  mem_word_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (req_idx),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      case (state_q)
        IDLE: begin
          // An X/Z d_ena evaluates false here, so it is not a request.
          if (bus.d_ena == 1'b1) begin
            idx_q   <= req_idx;
            wdata_q <= bus.wr_data;
            wr_q    <= bus.wr_dena;
            bad_q   <= req_bad;
            hold_q  <= ram_rdata;
            busy_q  <= 1'b1;
            cnt_q   <= LAT_INIT;
            if (LATENCY > 1) begin
              state_q <= WAIT;
            end else begin
              state_q   <= RESP;
              ack_q     <= 1'b1;
              err_q     <= req_bad;
              rd_data_q <= req_bad ? '0 : ram_rdata;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q   <= RESP;
            ack_q     <= 1'b1;
            err_q     <= bad_q;
            rd_data_q <= bad_q ? '0 : hold_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (WIDTH=32, DEPTH=256, LATENCY=2).
module tb_data_mem_responder;

  logic clock;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  data_mem_responder_if #(.WIDTH(32)) bus ();

  data_mem_responder #(
    .WIDTH   (32),
    .DEPTH   (256),
    .LATENCY (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request issued in the cycle after the current negedge; returns at the
  // negedge where ack is seen (lat counts negedges after the sampling edge).
  task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clock);
    bus.address = addr;
    bus.wr_data = wdata;
    bus.wr_dena = we;
    bus.d_ena   = 1'b1;
    @(negedge clock);
    bus.d_ena = 1'b0;
    lat = 1;
    while (bus.ack !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = bus.rd_data;
    er = bus.err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          stray_ack;

  initial begin
    reset       = 1'b1;
    bus.address = '0;
    bus.wr_data = '0;
    bus.wr_dena = 1'b0;
    bus.d_ena   = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_ack",  {31'b0, bus.ack},  32'h0);
    chk("reset_err",  {31'b0, bus.err},  32'h0);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_rd",   bus.rd_data,       32'h0);
    reset = 1'b0;

    // Read 0x10: busy for two cycles, ack in the second.
    @(negedge clock);
    bus.address = 32'h10;
    bus.wr_dena = 1'b0;
    bus.d_ena   = 1'b1;
    @(negedge clock);
    bus.d_ena = 1'b0;
    chk("t1_busy_c1", {31'b0, bus.busy}, 32'h1);
    chk("t1_ack_c1",  {31'b0, bus.ack},  32'h0);
    @(negedge clock);
    chk("t1_ack_c2",  {31'b0, bus.ack},  32'h1);
    chk("t1_err_c2",  {31'b0, bus.err},  32'h0);
    chk("t1_busy_c2", {31'b0, bus.busy}, 32'h1);
    @(negedge clock);
    chk("t1_ack_c3",  {31'b0, bus.ack},  32'h0);
    chk("t1_busy_c3", {31'b0, bus.busy}, 32'h0);
    chk("t1_rd_idle", bus.rd_data,       32'h0);

    // Write then back-to-back read of 0x20.
    req(32'h20, 32'hDEADBEEF, 1'b1, rd, er, lat);
    chk("t2_wr_lat", lat, 32'd2);
    chk("t2_wr_err", {31'b0, er}, 32'h0);
    req(32'h20, 32'h0, 1'b0, rd, er, lat);
    chk("t2_rd_lat",  lat, 32'd2);
    chk("t2_rd_data", rd,  32'hDEADBEEF);
    chk("t2_rd_err",  {31'b0, er}, 32'h0);

    // d_ena during busy (write 0x1 to 0x24) must be dropped.
    req(32'h24, 32'h12345678, 1'b1, rd, er, lat);
    @(negedge clock);
    bus.address = 32'h20;
    bus.wr_dena = 1'b0;
    bus.d_ena   = 1'b1;
    @(negedge clock);
    bus.address = 32'h24;
    bus.wr_data = 32'h1;
    bus.wr_dena = 1'b1;
    bus.d_ena   = 1'b1;
    @(negedge clock);
    chk("t3_ack",  {31'b0, bus.ack}, 32'h1);
    chk("t3_rd",   bus.rd_data,      32'hDEADBEEF);
    bus.d_ena = 1'b0;
    @(negedge clock);
    chk("t3_busy_after", {31'b0, bus.busy}, 32'h0);
    req(32'h24, 32'h0, 1'b0, rd, er, lat);
    chk("t3_rd_0x24", rd, 32'h12345678);

    // Out of range: 0x400 aliases word 0 but must not touch it.
    req(32'h0, 32'hCAFEF00D, 1'b1, rd, er, lat);
    req(32'h400, 32'h0, 1'b0, rd, er, lat);
    chk("t4_rd_err",  {31'b0, er}, 32'h1);
    chk("t4_rd_data", rd, 32'h0);
    chk("t4_rd_lat",  lat, 32'd2);
    req(32'h400, 32'h11111111, 1'b1, rd, er, lat);
    chk("t4_wr_err",  {31'b0, er}, 32'h1);
    req(32'h0, 32'h0, 1'b0, rd, er, lat);
    chk("t4_word0",   rd, 32'hCAFEF00D);
    chk("t4_word0_err", {31'b0, er}, 32'h0);

    // Reset during WAIT of a write to 0x30 aborts it.
    req(32'h30, 32'hA5A5A5A5, 1'b1, rd, er, lat);
    @(negedge clock);
    bus.address = 32'h30;
    bus.wr_data = 32'h55;
    bus.wr_dena = 1'b1;
    bus.d_ena   = 1'b1;
    @(negedge clock);
    bus.d_ena = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    chk("t5_ack_rst",  {31'b0, bus.ack},  32'h0);
    chk("t5_busy_rst", {31'b0, bus.busy}, 32'h0);
    reset = 1'b0;
    stray_ack = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.ack === 1'b1) stray_ack++;
    end
    chk("t5_no_ack", stray_ack, 32'd0);
    req(32'h30, 32'h0, 1'b0, rd, er, lat);
    chk("t5_old_val", rd, 32'hA5A5A5A5);

    // X on d_ena is not a request.
    @(negedge clock);
    bus.d_ena = 1'bx;
    @(negedge clock);
    bus.d_ena = 1'b0;
    chk("x_dena_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clock);

    // Misaligned read of 0x22.
    req(32'h22, 32'h0, 1'b0, rd, er, lat);
`ifdef MEM_ALIGN_CHECK_EN
    chk("t6_err", {31'b0, er}, 32'h1);
    chk("t6_rd",  rd, 32'h0);
`else
    chk("t6_err", {31'b0, er}, 32'h0);
    chk("t6_rd",  rd, 32'hDEADBEEF);
`endif

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
